image_fetch: RTL and testbench
==============================

# image_fetch

Sequencer that drives the read side of the image ROM: on a start request it walks the 784 pixels of one selected 28x28 image and presents them as a valid/ready pixel stream to the network input layer. It owns the ROM address bus, so the ROM needs no control logic of its own. It sits between the image ROM (8-bit data, 13-bit address, combinational read) and the first neural layer.

## Interface
- `PIXELS`, default 784: pixels per image.
- `NUM_IMAGES`, default 10: images stored back to back in the ROM.
- `ADDR_W`, default 13: ROM address width.
- `DATA_W`, default 8: pixel width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a fetch; sampled only in IDLE.
- `img_sel` in 4: image index, valid range 0..NUM_IMAGES-1.
- `busy` out 1: high from the cycle after an accepted start until done.
- `done` out 1: one-cycle pulse after the final pixel handshake.
- `err` out 1: one-cycle pulse when start is seen with img_sel ≥ NUM_IMAGES.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in DATA_W: ROM output, combinational from rom_addr.
- `pix_valid` out 1: pix_data is valid.
- `pix_ready` in 1: consumer accepts the pixel.
- `pix_data` out DATA_W: pixel value, registered.
- `pix_idx` out 10: index of the current pixel, 0..PIXELS-1.
- `pix_last` out 1: high with pix_valid when pix_idx == PIXELS-1.

## Operation
The block is a state machine with three states: IDLE, PRIME and STREAM.

- **Reset.** All outputs go to 0 and the state goes to IDLE.
- **IDLE, start with an in-range img_sel.**
  - rom_addr ← img_sel*PIXELS, computed at ADDR_W width. The maximum end address is 7840, below 8192, so it never wraps.
  - busy ← 1, next state PRIME.
- **IDLE, start with img_sel ≥ NUM_IMAGES.** err pulses for 1 cycle. The state stays IDLE, busy stays 0 and no ROM access occurs.
- **PRIME.**
  - pix_data ← rom_data, pix_idx ← 0, pix_valid ← 1.
  - rom_addr ← rom_addr+1, next state STREAM.
- **STREAM, handshake (pix_valid && pix_ready) and not pix_last.**
  - pix_data ← rom_data. rom_addr already points at the next pixel.
  - pix_idx ← pix_idx+1, rom_addr ← rom_addr+1.
- **STREAM, handshake with pix_last.**
  - pix_valid ← 0, busy ← 0, done ← 1 for 1 cycle, next state IDLE.
  - rom_addr keeps its value; it may point one past the image, which is harmless.
- **STREAM, no handshake.** pix_data, pix_idx, pix_last and rom_addr all hold. pix_valid is never withdrawn without a handshake.
- **pix_last** is derived from pix_idx == PIXELS-1 and is qualified by pix_valid.
- **start while busy** is ignored: no queueing and no err.
- **start on the same edge as done** is not accepted, because the state is not yet IDLE. It is accepted one cycle later if it is still asserted.
- **rst_n asserted mid-stream** immediately clears all state. There is no done pulse and no partial completion. After release the block waits in IDLE.

## Timing
- Start is accepted at edge E0. After E0 rom_addr equals the base address; after E1 pix_valid is 1 with pixel 0.
- With pix_ready held high, throughput is 1 pixel per clock and handshakes occur at edges E2..E(PIXELS+1).
- done is high in the cycle after edge E(PIXELS+1). With PIXELS = 784 that is 786 edges after start.
- Each cycle pix_ready is low adds exactly one cycle of latency.
- rom_data must settle within the cycle following any rom_addr change. The ROM has zero read latency, and no extra pipeline stage is needed.

## Configuration
- `IMAGE_FETCH_CHECKSUM_EN` defined:
  - Adds output `checksum` (16 bits).
  - It is cleared on accepted start and accumulates a modulo-2^16 sum of pix_data at every handshake.
  - It holds its value from the done pulse until the next accepted start. Reset value is 0.
- Not defined: the port and the adder are absent. All other behaviour is identical.

## Test plan
The bench ROM model returns rom_data = rom_addr[7:0].

- **Reset check.** Hold rst_n low → busy, done, err, pix_valid, pix_data, pix_idx and rom_addr are all 0.
- **Image 0, pix_ready tied high.** start, img_sel=0 →
  - first pixel 0x00 at idx 0, then 784 consecutive handshakes;
  - last pixel 0x0F with pix_last=1;
  - done exactly 786 edges after start;
  - with the macro defined, checksum = 0x7EF8.
- **Bounds of image selection.**
  - img_sel=1 → first pixel 0x10 (address 784).
  - img_sel=9 → last pixel 0x9F (address 7839).
  - img_sel=10 → err pulses once, busy stays 0 and no pix_valid appears.
- **Backpressure.** pix_ready toggles with a pseudo-random pattern →
  - pix_data, pix_idx and rom_addr hold whenever ready is low;
  - the pixel sequence is identical to the tied-high run;
  - done follows the 784th handshake by 1 cycle.
- **Mid-operation events.**
  - Pulse start while streaming → ignored; the stream is unchanged.
  - Assert rst_n low at pixel 300 → all outputs 0 immediately and no done.
  - A new start after release streams image 0 from pixel 0.

Source files
------------

// File: rtl/image_fetch.sv
// image_fetch: walks one 28x28 image in the ROM and streams its pixels out valid/ready.
// Latency: pixel 0 valid two cycles after an accepted start; then 1 pixel/clock while pix_ready is high.
// Backpressure: pix_ready low holds pix_data/pix_idx/rom_addr; pix_valid is never dropped without a handshake.
// Optional IMAGE_FETCH_CHECKSUM_EN adds a 16-bit running sum of the streamed pixels.
module image_fetch #(
  parameter int PIXELS     = 784,
  parameter int NUM_IMAGES = 10,
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        img_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [DATA_W-1:0] pix_data,
  output logic [9:0]        pix_idx,
`ifdef IMAGE_FETCH_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic              pix_last
);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  localparam logic [ADDR_W-1:0] PIX_A    = ADDR_W'(PIXELS);
  localparam logic [9:0]        LAST_IDX = 10'(PIXELS - 1);
  localparam logic [4:0]        NUM_SEL  = 5'(NUM_IMAGES);

  state_t              state, state_nx;
  logic                busy_nx, done_nx, err_nx, valid_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic [DATA_W-1:0]   data_nx;
  logic [9:0]          idx_nx;
  logic                sel_ok;
  logic                hs;

  assign sel_ok   = ({1'b0, img_sel} < NUM_SEL);
  assign hs       = pix_valid && pix_ready;
  assign pix_last = pix_valid && (pix_idx == LAST_IDX);

  // Next-state and next-register values; everything holds unless the state says otherwise.
  always_comb begin
    state_nx = state;
    busy_nx  = busy;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    addr_nx  = rom_addr;
    valid_nx = pix_valid;
    data_nx  = pix_data;
    idx_nx   = pix_idx;
    case (state)
      IDLE: begin
        if (start) begin
          if (sel_ok) begin
            // Largest base plus image length stays below 2^ADDR_W, so no wrap.
            addr_nx  = ADDR_W'(img_sel) * PIX_A;
            busy_nx  = 1'b1;
            state_nx = PRIME;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      PRIME: begin
        // ROM is combinational: rom_data already reflects the base address.
        data_nx  = rom_data;
        idx_nx   = 10'd0;
        valid_nx = 1'b1;
        addr_nx  = rom_addr + ADDR_W'(1);
        state_nx = STREAM;
      end
      STREAM: begin
        if (hs) begin
          if (pix_last) begin
            // rom_addr is left one past the image; nobody reads it.
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            data_nx = rom_data;
            idx_nx  = pix_idx + 10'd1;
            addr_nx = rom_addr + ADDR_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rom_addr  <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
      pix_idx   <= '0;
    end else begin
      state     <= state_nx;
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      rom_addr  <= addr_nx;
      pix_valid <= valid_nx;
      pix_data  <= data_nx;
      pix_idx   <= idx_nx;
    end
  end

`ifdef IMAGE_FETCH_CHECKSUM_EN
  // Running pixel sum: cleared on an accepted start, frozen after done until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (state == IDLE && start && sel_ok) begin
      checksum <= '0;
    end else if (hs) begin
      checksum <= checksum + 16'(pix_data);
    end
  end
`endif

endmodule

// File: tb/tb_image_fetch.sv
// Bench for image_fetch: scoreboard of expected pixels fed by stimulus, popped by a negedge monitor.
// ROM model returns the low byte of the address; pix_ready is either tied high or randomised.
// Optional IMAGE_FETCH_CHECKSUM_EN also checks the running checksum against the model sum.
module tb_image_fetch;
  localparam int PIXELS = 784;

  logic        clk = 1'b0;
  logic        rst_n, start, pix_ready;
  logic [3:0]  img_sel;
  logic        busy, done, err, pix_valid, pix_last;
  logic [12:0] rom_addr;
  logic [7:0]  rom_data, pix_data;
  logic [9:0]  pix_idx;
`ifdef IMAGE_FETCH_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;
  assign rom_data = rom_addr[7:0];

  image_fetch dut (
    .clk(clk), .rst_n(rst_n), .start(start), .img_sel(img_sel),
    .busy(busy), .done(done), .err(err), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data), .pix_idx(pix_idx),
`ifdef IMAGE_FETCH_CHECKSUM_EN
    .checksum(checksum),
`endif
    .pix_last(pix_last)
  );

  typedef struct { int data; int idx; bit last; } exp_t;
  exp_t q[$];
  exp_t e;

  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int hs_cnt = 0;
  int last_hs_edge = 0;
  int done_cnt = 0;
  bit rnd_ready = 1'b0;
  bit p_valid = 1'b0, p_ready = 1'b0;
  logic [7:0]  p_data;
  logic [9:0]  p_idx;
  logic [12:0] p_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge counter: value equals the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: ready either tied high or random, changed just after each edge.
  always @(posedge clk) begin
    #1;
    pix_ready = rnd_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Monitor: a handshake is committed at the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (pix_valid && pix_ready) begin
      if (q.size() == 0) begin
        check("unexpected_pixel", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("pix_data", 32'(pix_data), 32'(e.data));
        check("pix_idx",  32'(pix_idx),  32'(e.idx));
        check("pix_last", 32'(pix_last), 32'(e.last));
      end
      hs_cnt++;
      last_hs_edge = cyc + 1;
    end
    if (p_valid && !p_ready && pix_valid) begin
      check("hold_data", 32'(pix_data), 32'(p_data));
      check("hold_idx",  32'(pix_idx),  32'(p_idx));
      check("hold_addr", 32'(rom_addr), 32'(p_addr));
    end
    p_valid = pix_valid;
    p_ready = pix_ready;
    p_data  = pix_data;
    p_idx   = pix_idx;
    p_addr  = rom_addr;
    if (done) done_cnt++;
  end

  // Reference: image sel occupies addresses sel*PIXELS .. sel*PIXELS+PIXELS-1.
  task automatic push_image(input int sel, output int sum);
    sum = 0;
    for (int i = 0; i < PIXELS; i++) begin
      int a;
      a = sel * PIXELS + i;
      q.push_back('{data: a % 256, idx: i, last: (i == PIXELS - 1)});
      sum += a % 256;
    end
  endtask

  task automatic issue_start(input int sel);
    @(posedge clk); #1;
    start = 1'b1;
    img_sel = 4'(sel);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_image(input int sel, input bit random_ready);
    int sum;
    int n;
    bit got;
    rnd_ready = random_ready;
    hs_cnt = 0;
    push_image(sel, sum);
    issue_start(sel);
    check("busy_after_start", 32'(busy), 32'd1);
    check("base_addr", 32'(rom_addr), 32'(sel * PIXELS));
    n = 1;
    got = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      @(posedge clk); #1;
      n++;
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(got), 32'd1);
    if (!random_ready) check("done_edges", 32'(n), 32'(PIXELS + 2));
    check("done_after_last_hs", 32'(cyc), 32'(last_hs_edge));
    check("hs_count", 32'(hs_cnt), 32'(PIXELS));
    check("queue_empty", 32'(q.size()), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
`ifdef IMAGE_FETCH_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum % 65536));
`endif
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'd0);
    rnd_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_data"}, 32'(pix_data), 32'd0);
    check({tag, "_idx"}, 32'(pix_idx), 32'd0);
    check({tag, "_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    int vcnt, ecnt, d0, sum, rsel;
    rst_n = 1'b0;
    start = 1'b0;
    img_sel = 4'd0;
    pix_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Image 0 with ready tied high, then the neighbouring and last images.
    run_image(0, 1'b0);
    run_image(1, 1'b0);
    run_image(9, 1'b1);

    // Out-of-range selection: single err pulse, no stream, ROM address untouched.
    issue_start(10);
    check("err_pulse", 32'(err), 32'd1);
    check("err_busy", 32'(busy), 32'd0);
    vcnt = 0;
    ecnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (pix_valid) vcnt++;
      if (err) ecnt++;
    end
    check("err_no_valid", 32'(vcnt), 32'd0);
    check("err_once", 32'(ecnt), 32'd0);
    check("err_addr_held", 32'(rom_addr), 32'(10 * PIXELS));

    // Random image with random backpressure.
    rsel = $urandom_range(0, 9);
    run_image(rsel, 1'b1);

    // Start while streaming is ignored; reset at pixel 300 kills the stream.
    hs_cnt = 0;
    push_image(2, sum);
    issue_start(2);
    for (int k = 0; k < 2000 && hs_cnt < 100; k++) begin
      @(posedge clk); #1;
    end
    check("reach_pixel_100", 32'(hs_cnt >= 100), 32'd1);
    start = 1'b1;
    img_sel = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start_ignored", 32'(busy), 32'd1);
    check("err_start_ignored", 32'(err), 32'd0);
    for (int k = 0; k < 2000 && hs_cnt < 300; k++) begin
      @(posedge clk); #1;
    end
    check("reach_pixel_300", 32'(hs_cnt >= 300), 32'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("no_done_after_reset", 32'(done_cnt), 32'(d0));
    check("idle_after_reset", 32'(pix_valid), 32'd0);

    // After release a fresh start streams image 0 from pixel 0.
    run_image(0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
